// File: rtl/detect_event_logger_pkg.sv
// Shared defaults and pointer-width helper for the event logger and its FIFO.
package detect_event_logger_pkg;

  localparam int unsigned TS_WIDTH_DEF  = 16;
  localparam int unsigned CNT_WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF     = 4;

  // Pointer carries one wrap bit above the index so full and empty are distinguishable.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/detect_event_logger_event_fifo.sv
// Synchronous show-ahead FIFO; head entry is presented on dout while non-empty.
module event_fifo
  import detect_event_logger_pkg::*;
#(
  parameter int unsigned WIDTH = TS_WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        clr,
  input  logic [WIDTH-1:0]            din,
  output logic                        full,
  output logic                        empty,
  output logic [ptr_width(DEPTH)-1:0] level,
  output logic [WIDTH-1:0]            dout
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  // Storage needs no reset: dout is gated by empty.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wptr[AW-1:0]] <= din;
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign level = wptr - rptr;
  assign dout  = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/detect_event_logger.sv
// Turns each rising edge of the detector output into a timestamped, counted, buffered event.
module detect_event_logger
  import detect_event_logger_pkg::*;
#(
  parameter int unsigned TS_WIDTH  = TS_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        yin,
  input  logic                        clr,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [TS_WIDTH-1:0]         ev_ts,
  output logic [CNT_WIDTH-1:0]        ev_count,
  output logic [ptr_width(DEPTH)-1:0] fifo_level,
  output logic                        overflow
);

  logic                yin_d;
  logic [TS_WIDTH-1:0] ts;
  logic                ev;
  logic                pop;
  logic                push;
  logic                full;
  logic                empty;

  assign ev       = yin & ~yin_d;
  assign ev_valid = ~empty;
  assign pop      = ev_valid & ev_ready & ~clr;
  // A full FIFO still accepts the event when the head leaves in the same cycle.
  assign push     = ev & ~clr & (~full | pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      yin_d    <= 1'b0;
      ts       <= '0;
      ev_count <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      yin_d    <= 1'b0;
      ts       <= '0;
      ev_count <= '0;
      overflow <= 1'b0;
    end else begin
      yin_d <= yin;
      ts    <= ts + TS_WIDTH'(1);
      if (ev) begin
        if (ev_count != '1) ev_count <= ev_count + CNT_WIDTH'(1);
        if (full && !pop)   overflow <= 1'b1;
      end
    end
  end

  event_fifo #(
    .WIDTH (TS_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clr   (clr),
    .din   (ts),
    .full  (full),
    .empty (empty),
    .level (fifo_level),
    .dout  (ev_ts)
  );

endmodule

// File: tb/tb_detect_event_logger.sv
// Drives a default-width logger and a narrow (TS=4, CNT=2) logger with identical stimulus against one queue model.
module tb_detect_event_logger;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic yin = 1'b0;
  logic clr = 1'b0;
  logic ev_ready = 1'b0;

  logic        ev_valid, overflow;
  logic [15:0] ev_ts;
  logic [7:0]  ev_count;
  logic [2:0]  fifo_level;

  logic        s_ev_valid, s_overflow;
  logic [3:0]  s_ev_ts;
  logic [1:0]  s_ev_count;
  logic [2:0]  s_fifo_level;

  int checks = 0;
  int errors = 0;

  int mq[$];
  int m_ts  = 0;
  bit m_yd  = 1'b0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;

  always #5 clk = ~clk;

  detect_event_logger dut (
    .clk        (clk),
    .reset      (reset),
    .yin        (yin),
    .clr        (clr),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_ts      (ev_ts),
    .ev_count   (ev_count),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  detect_event_logger #(.TS_WIDTH(4), .CNT_WIDTH(2), .DEPTH(4)) dut_s (
    .clk        (clk),
    .reset      (reset),
    .yin        (yin),
    .clr        (clr),
    .ev_valid   (s_ev_valid),
    .ev_ready   (ev_ready),
    .ev_ts      (s_ev_ts),
    .ev_count   (s_ev_count),
    .fifo_level (s_fifo_level),
    .overflow   (s_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_ts  = 0;
    m_yd  = 1'b0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endfunction

  // One clock edge of the logger, in terms of a queue of timestamps.
  function automatic void model_edge();
    bit e, p, f;
    if (!reset || clr) begin
      model_reset();
      return;
    end
    e = yin && !m_yd;
    p = (mq.size() > 0) && ev_ready;
    f = (mq.size() == 4);
    if (p) void'(mq.pop_front());
    if (e) begin
      if (m_cnt < 255) m_cnt++;
      if (f && !p) m_ovf = 1'b1;
      else mq.push_back(m_ts);
    end
    m_yd = yin;
    m_ts = (m_ts + 1) % 65536;
  endfunction

  task automatic compare_all();
    int sz, head;
    sz   = mq.size();
    head = (sz != 0) ? mq[0] : 0;
    check("valid",     32'(ev_valid),     32'(sz != 0));
    check("ts",        32'(ev_ts),        32'(head));
    check("count",     32'(ev_count),     32'(m_cnt));
    check("level",     32'(fifo_level),   32'(sz));
    check("ovf",       32'(overflow),     32'(m_ovf));
    check("s_valid",   32'(s_ev_valid),   32'(sz != 0));
    check("s_ts",      32'(s_ev_ts),      32'(head % 16));
    check("s_count",   32'(s_ev_count),   32'((m_cnt > 3) ? 3 : m_cnt));
    check("s_level",   32'(s_fifo_level), 32'(sz));
    check("s_ovf",     32'(s_overflow),   32'(m_ovf));
  endtask

  task automatic cyc(input logic y, input logic r, input logic c);
    yin      = y;
    ev_ready = r;
    clr      = c;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    // Reset held two cycles, then idle.
    #1;
    compare_all();
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    reset = 1'b1;
    repeat (3) cyc(0, 0, 0);
    check("rst_valid", 32'(ev_valid), 32'd0);
    check("rst_count", 32'(ev_count), 32'd0);

    // Single event sampled at ts = 5, held high three cycles.
    repeat (2) cyc(0, 0, 0);
    repeat (3) cyc(1, 0, 0);
    check("single_ts",    32'(ev_ts),      32'd5);
    check("single_count", 32'(ev_count),   32'd1);
    check("single_level", 32'(fifo_level), 32'd1);
    cyc(0, 1, 0);
    check("single_pop", 32'(ev_valid), 32'd0);

    // Overflow: five pulses into a four-entry FIFO with no draining.
    cyc(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_count", 32'(ev_count),   32'd5);
    check("ovf_flag",  32'(overflow),   32'd1);
    check("ovf_head",  32'(ev_ts),      32'd0);

    // Full FIFO with a simultaneous push and pop.
    cyc(0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
    cyc(1, 1, 0);
    check("pp_level", 32'(fifo_level), 32'd4);
    check("pp_ovf",   32'(overflow),   32'd0);
    check("pp_head",  32'(ev_ts),      32'd2);

    // Clear wins over a same-cycle event and pop.
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    check("pre_clr_level", 32'(fifo_level), 32'd2);
    cyc(1, 1, 1);
    check("clr_level", 32'(fifo_level), 32'd0);
    check("clr_count", 32'(ev_count),   32'd0);
    check("clr_ovf",   32'(overflow),   32'd0);
    cyc(1, 0, 0);
    check("clr_ts0", 32'(ev_ts), 32'd0);

    // Saturation of the narrow counter and wrap of the narrow timestamp.
    cyc(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      cyc(0, 1, 0);
      cyc(0, 0, 0);
    end
    check("sat_s_count", 32'(s_ev_count), 32'd3);
    check("sat_count",   32'(ev_count),   32'd5);

    // Randomized traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 800; i++) begin
      logic y, r, c;
      if (i == 400) begin
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        cyc(0, 0, 0);
        reset = 1'b1;
      end
      y = 1'($urandom_range(0, 1));
      r = ((i % 200) < 100) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 49) == 0);
      cyc(y, r, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/detect_event_logger.md
# detect_event_logger

Downstream consumer of the Moore sequence detector's `yout` line. Converts each new assertion of the detector output into one event: it stamps the event with a free-running cycle timestamp, counts it in a saturating total, and buffers the timestamp in a small show-ahead FIFO. A host or testbench drains the FIFO through a valid/ready port, so no event is lost between polls until the buffer overflows.

## Interface
- `TS_WIDTH`, 16, timestamp counter width.
- `CNT_WIDTH`, 8, total event counter width.
- `DEPTH`, 4, FIFO entries; must be a power of two and at least 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `yin`  in  1  detector output (`yout` of the sequence detector).
- `clr`  in  1  synchronous clear: flushes the FIFO and zeroes the timestamp, count and overflow.
- `ev_valid`  out  1  FIFO non-empty.
- `ev_ready`  in  1  consumer accepts the head entry.
- `ev_ts`  out  TS_WIDTH  timestamp of the head entry; valid only while `ev_valid` is 1.
- `ev_count`  out  CNT_WIDTH  total events detected, saturating.
- `fifo_level`  out  $clog2(DEPTH)+1  number of entries currently held.
- `overflow`  out  1  sticky; set when an event was dropped because the FIFO was full.

## Operation
- `ts`: free-running counter, +1 every cycle, wraps from 2^TS_WIDTH-1 to 0.
- `yin_d`: `yin` registered one cycle.
- `event = yin & ~yin_d` (rising edge). A `yin` held high for several cycles gives exactly one event.
- On `event` at edge k:
  - push `ts` as it was before the increment at edge k;
  - `ev_count` +1, holding at 2^CNT_WIDTH-1.
- Pop: `ev_valid & ev_ready` at an edge advances the read pointer.
- `ev_ready` while empty: no effect.
- Full FIFO, event, no pop in the same cycle:
  - the event is dropped and `overflow` is set;
  - `ev_count` still increments, since it counts detections, not stored events.
- Full FIFO, event and pop in the same cycle: both take effect; `fifo_level` stays at DEPTH; no overflow.
- Empty FIFO, event, `ev_ready` high: push only. Show-ahead output is not bypassed, so the entry pops no earlier than the next edge.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally:
  - full = same index bits, MSBs differ;
  - empty = pointers equal.
- `clr` has priority over every other action in the same cycle. It sets:
  - FIFO empty;
  - `ts` = 0 and `yin_d` = 0;
  - `ev_count` = 0 and `overflow` = 0.
  Any event or pop in that cycle is discarded.
- `overflow` clears only on `clr` or `reset`.

## Timing
- Reset values (`reset` low, asynchronous):
  - `ts` = 0, `yin_d` = 0;
  - `ev_valid` = 0, `ev_ts` = 0 (memory contents don't-care, output gated);
  - `ev_count` = 0, `fifo_level` = 0, `overflow` = 0.
- Reset release is sampled at `clk`. The first edge after release is treated as `ts` = 0.
- Latency from `yin` rising (sampled at edge k):
  - `ev_valid` and `ev_count` update after edge k (1 cycle);
  - `ev_ts` shows the entry in the same cycle as `ev_valid`.
- `ev_ts`, `ev_valid` and `fifo_level` derive combinationally from registered state only; there is no combinational path from any input.
- Reset asserted mid-operation: all outputs go to their reset values immediately, without waiting for a clock edge; buffered entries are lost.

## Structure
- A shared header/package holds the default `TS_WIDTH`, `CNT_WIDTH` and `DEPTH` constants and a `$clog2`-based pointer-width macro, reused by the detector benches.
- One sub-module, `event_fifo`: synchronous show-ahead FIFO, parameterised by width and depth. It has ports push, pop, clr, full, empty, level and dout, uses the same `clk`/`reset`, and has no drop logic.
- The top level holds the edge detector, timestamp counter, saturating counter and overflow flag.

## Test plan
- Reset: hold `reset`=0 for 2 cycles, then release and drive `yin`=0 for 3 cycles. Expect `ev_valid`=0, `ev_count`=0, `overflow`=0 throughout, and `ts` at 3 after those edges.
- Single event: after release, `yin`=1 at the edge where `ts`=5 and held for 3 cycles. Expect exactly one entry with `ev_ts`=5, `ev_count`=1, `fifo_level`=1; pop with `ev_ready`=1 gives `ev_valid`=0 on the next cycle.
- Overflow (DEPTH=4, `ev_ready`=0): apply 5 one-cycle `yin` pulses separated by a 0 cycle. Expect `fifo_level`=4, `ev_count`=5, `overflow`=1, and the FIFO holds the first 4 timestamps in order.
- Full FIFO with simultaneous push and pop: an event and `ev_ready`=1 at the same edge. Expect `fifo_level` to stay at 4, `overflow` to stay 0, and the newest timestamp to land at the tail.
- Clear priority: a FIFO holding 2 entries, then `clr`=1 in the same cycle as a `yin` rise and `ev_ready`=1. Expect `fifo_level`=0, `ev_count`=0, `overflow`=0 and `ts`=0 on the next cycle.
- Saturation and wrap (CNT_WIDTH=2, TS_WIDTH=4): apply 5 pulses across 20 cycles. Expect `ev_count` to hold at 3 and the stored timestamps to wrap through 15 to 0.
